exc_ctrl: RTL
=============

# exc_ctrl

Exception and ERET sequencer between the write-back stage and the CP0 register block. It prioritises the exception sources a committing instruction carries, plus a sampled external/timer interrupt, into one excode. In the commit cycle it drives the CP0 update strobes. It then flushes the pipeline and hands a redirect PC to fetch through a valid/ready handshake.

## Interface
Parameters:
- EX_ENTRY, 32'hbfc00380: exception vector (BEV=1).
- FLUSH_CYCLES, 2: minimum cycles `pipe_flush` stays high before the redirect is offered; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- ws_valid  in  1  write-back stage holds a valid instruction this cycle.
- ws_ex_vec  in  7  exception sources: [0] ADEL fetch, [1] RI, [2] OV, [3] SYS, [4] BP, [5] ADEL load, [6] ADES store.
- ws_eret  in  1  instruction is ERET.
- ws_bd  in  1  instruction is in a branch delay slot.
- ws_pc  in  32  instruction PC.
- ws_data_addr  in  32  load/store effective address.
- c0_status_ie  in  1  Status.IE.
- c0_status_exl  in  1  Status.EXL.
- c0_status_im  in  8  Status.IM.
- c0_cause_ip  in  8  Cause.IP.
- c0_epc  in  32  EPC.
- wb_ex  out  1  exception commit strobe to CP0.
- wb_excode  out  5  excode.
- wb_bd  out  1  delay-slot flag.
- wb_pc  out  32  PC to CP0.
- wb_badvaddr  out  32  bad address.
- eret_flush  out  1  ERET commit strobe to CP0.
- pipe_flush  out  1  kill all in-flight instructions.
- redirect_valid  out  1  redirect offered to fetch.
- redirect_pc  out  32  redirect target.
- redirect_ready  in  1  fetch accepts the redirect.
- busy  out  1  state != IDLE.

## Operation
- States:
  - IDLE: normal commit.
  - FLUSH: count down the minimum flush length.
  - REDIRECT: wait for the fetch handshake.
- Interrupt sampling:
  - `int_pending` register <= `c0_status_ie & ~c0_status_exl & |(c0_status_im & c0_cause_ip)`, every cycle.
- Event detection, IDLE only:
  - `take_ex = ws_valid & (int_pending | |ws_ex_vec)`.
  - `take_eret = ws_valid & ws_eret & ~take_ex`. An exception always wins over ERET.
- Priority, highest first, with excode:
  - INT 0x00
  - ADEL fetch 0x04
  - RI 0x0a
  - OV 0x0c
  - SYS 0x08
  - BP 0x09
  - ADEL load 0x04
  - ADES 0x05
- Commit outputs, combinational in the event cycle, so CP0 updates on that same edge:
  - `wb_ex = take_ex`; `eret_flush = take_eret`.
  - `wb_bd = ws_bd`; `wb_pc = ws_pc`.
  - `wb_badvaddr = ws_pc` for ADEL fetch, otherwise `ws_data_addr`.
  - All five commit outputs are 0 outside IDLE.
- On an event:
  - Capture the target: EX_ENTRY for an exception, `c0_epc` as sampled in the event cycle for ERET.
  - Load the counter with FLUSH_CYCLES-1 and move to FLUSH.
- FLUSH:
  - `pipe_flush` = 1; counter decrements each cycle.
  - Counter reaches 0 -> REDIRECT.
- REDIRECT:
  - `pipe_flush` = 1; `redirect_valid` = 1; `redirect_pc` held stable.
  - `redirect_valid & redirect_ready` -> IDLE.
- `ws_valid` and `ws_ex_vec` are ignored while not in IDLE.

## Timing
- Reset: state IDLE, counter 0, `int_pending` 0, captured target 0. All outputs 0.
- Reset mid-FLUSH or mid-REDIRECT: IDLE next cycle, redirect dropped, no strobe emitted.
- `pipe_flush` rises in the cycle after the event and is 0 in the event cycle itself.
- `redirect_valid` first rises FLUSH_CYCLES cycles after the event cycle.
- `redirect_ready` may arrive in the same cycle `redirect_valid` rises; the handshake then completes that cycle.
- The earliest next commit is the cycle after the handshake.
- Minimum event-to-event spacing is FLUSH_CYCLES+1 cycles.
- Interrupt latency: an IP/IM/IE change is visible in `int_pending` one cycle later. It is taken on the next `ws_valid` cycle in IDLE.
- An interrupt on an ERET instruction reports INT and ERET is suppressed.

## Configuration
- `EXC_CTRL_INT_EN`:
  - Defined: interrupt sampling and the INT priority level as above.
  - Undefined: `int_pending` is constant 0, the IE/EXL/IM/IP inputs are unused, and only synchronous exceptions and ERET are sequenced.

## Structure
- Shared package/header `mycpu.h`: EXC_* excode constants, the `ws_ex_vec` bit indices, and the default EX_ENTRY.
- Optional sub-module `exc_prio_enc`: a combinational priority encoder from {int, ws_ex_vec} to {any, excode, is_fetch_adel}.

## Test plan
- SYS on a non-delay-slot commit, pc 0xbfc01000:
  - `wb_ex`=1, excode 0x08, `wb_pc`=0xbfc01000, `wb_bd`=0.
  - `redirect_pc`=0xbfc00380 two cycles later.
- RI and OV asserted together:
  - Excode 0x0a.
- ADEL fetch and ADES asserted together:
  - Excode 0x04, `wb_badvaddr`=`ws_pc`.
- ERET with `c0_epc`=0x1234:
  - `eret_flush` pulses one cycle, `redirect_pc`=0x1234.
  - ERET together with OV: OV taken, no `eret_flush`.
- IE=1, EXL=0, IM[7]=1, IP[7]=1, then a commit:
  - Excode 0x00.
  - With EXL=1 instead: no exception taken.
- `redirect_ready` held low for 5 cycles:
  - `redirect_valid` and `redirect_pc` stable; a new `ws_valid`+SYS is ignored.
  - `rst` during the wait: all outputs 0 the next cycle.

Source files
------------

// File: rtl/exc_ctrl_pkg.sv
// Shared exception constants: excodes, ws_ex_vec bit positions, vector address.
// The optional interrupt path is built when EXC_CTRL_INT_EN is defined.
package exc_ctrl_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  localparam int EX_ADEL_IF = 0;
  localparam int EX_RI      = 1;
  localparam int EX_OV      = 2;
  localparam int EX_SYS     = 3;
  localparam int EX_BP      = 4;
  localparam int EX_ADEL_LD = 5;
  localparam int EX_ADES    = 6;

  localparam logic [31:0] EX_ENTRY_DEF = 32'hbfc00380;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    REDIRECT
  } exc_state_t;

endpackage

// File: rtl/exc_ctrl_prio.sv
// Priority encoder from {interrupt, exception sources} to one excode.
// Fetch ADEL is flagged so the top can pick the PC as bad address.
module exc_prio_enc
  import exc_ctrl_pkg::*;
(
  input  logic       irq,
  input  logic [6:0] ex_vec,
  output logic       any,
  output logic [4:0] excode,
  output logic       fetch_adel
);

  always_comb begin
    any        = irq | (|ex_vec);
    excode     = EXC_INT;
    fetch_adel = 1'b0;
    if (irq) begin
      excode = EXC_INT;
    end else if (ex_vec[EX_ADEL_IF]) begin
      excode     = EXC_ADEL;
      fetch_adel = 1'b1;
    end else if (ex_vec[EX_RI]) begin
      excode = EXC_RI;
    end else if (ex_vec[EX_OV]) begin
      excode = EXC_OV;
    end else if (ex_vec[EX_SYS]) begin
      excode = EXC_SYS;
    end else if (ex_vec[EX_BP]) begin
      excode = EXC_BP;
    end else if (ex_vec[EX_ADEL_LD]) begin
      excode = EXC_ADEL;
    end else if (ex_vec[EX_ADES]) begin
      excode = EXC_ADES;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception / ERET sequencer: commit strobes to CP0, flush, fetch redirect.
// Define EXC_CTRL_INT_EN to enable sampled interrupts at top priority.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EX_ENTRY     = EX_ENTRY_DEF,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ws_valid,
  input  logic [6:0]  ws_ex_vec,
  input  logic        ws_eret,
  input  logic        ws_bd,
  input  logic [31:0] ws_pc,
  input  logic [31:0] ws_data_addr,
  input  logic        c0_status_ie,
  input  logic        c0_status_exl,
  input  logic [7:0]  c0_status_im,
  input  logic [7:0]  c0_cause_ip,
  input  logic [31:0] c0_epc,
  output logic        wb_ex,
  output logic [4:0]  wb_excode,
  output logic        wb_bd,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_badvaddr,
  output logic        eret_flush,
  output logic        pipe_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        busy
);

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  exc_state_t  state;
  exc_state_t  state_nx;
  logic [3:0]  cnt;
  logic [31:0] target;
  logic        int_pending;
  logic        any;
  logic        fetch_adel;
  logic [4:0]  excode;
  logic        idle;
  logic        take_ex;
  logic        take_eret;
  logic        event_c;

`ifdef EXC_CTRL_INT_EN
  always_ff @(posedge clk) begin
    if (rst) int_pending <= 1'b0;
    else int_pending <= c0_status_ie & ~c0_status_exl
                      & (|(c0_status_im & c0_cause_ip));
  end
`else
  logic unused_c0;
  assign unused_c0 = ^{c0_status_ie, c0_status_exl,
                       c0_status_im, c0_cause_ip};
  assign int_pending = 1'b0;
`endif

  exc_prio_enc u_prio (
    .irq        (int_pending),
    .ex_vec     (ws_ex_vec),
    .any        (any),
    .excode     (excode),
    .fetch_adel (fetch_adel)
  );

  // a reset cycle never emits a commit strobe
  assign idle      = (state == IDLE) & ~rst;
  assign take_ex   = idle & ws_valid & any;
  assign take_eret = idle & ws_valid & ws_eret & ~take_ex;
  assign event_c   = take_ex | take_eret;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (event_c)
        state_nx = (FLUSH_CYCLES == 1) ? REDIRECT : FLUSH;
      FLUSH: if (cnt == 4'd1) state_nx = REDIRECT;
      REDIRECT: if (redirect_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= 4'd0;
      target <= 32'd0;
    end else if (event_c) begin
      cnt    <= CNT_INIT;
      target <= take_ex ? EX_ENTRY : c0_epc;
    end else if (state == FLUSH) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    wb_ex          = 1'b0;
    eret_flush     = 1'b0;
    wb_excode      = 5'd0;
    wb_bd          = 1'b0;
    wb_pc          = 32'd0;
    wb_badvaddr    = 32'd0;
    pipe_flush     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    unique case (state)
      IDLE: begin
        wb_ex      = take_ex;
        eret_flush = take_eret;
        if (take_ex) wb_excode = excode;
        if (event_c) begin
          wb_bd       = ws_bd;
          wb_pc       = ws_pc;
          wb_badvaddr = fetch_adel ? ws_pc : ws_data_addr;
        end
      end
      FLUSH: pipe_flush = 1'b1;
      REDIRECT: begin
        pipe_flush     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = target;
      end
      default: ;
    endcase
  end

endmodule
